// File: rtl/field_bank_arbiter_pkg.sv
// rtl/field_bank_arbiter_pkg.sv - shared state and bank-select types for the field bank arbiter
package field_bank_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GNT_NFI   = 3'd1,
        GNT_FCL   = 3'd2,
        RUN_NFI   = 3'd3,
        RUN_FCL   = 3'd4,
        SWAP_WAIT = 3'd5
    } fba_state_t;

    typedef enum logic {
        BANK_A = 1'b0,
        BANK_B = 1'b1
    } bank_sel_t;

endpackage

// File: rtl/field_bank_arbiter.sv
// rtl/field_bank_arbiter.sv - double-buffered field bank arbiter between iterator and loader; FBA_VBLANK_SYNC_EN holds the swap for vblank
// Grants the back bank to one engine per job and swaps front/back once the job completes.
module field_bank_arbiter
    import field_bank_arbiter_pkg::*;
#(
    parameter int FCL_PRIO      = 1,
    parameter int START_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_nfi_req,
    input  logic i_fcl_req,
    input  logic i_nfi_busy,
    input  logic i_fcl_busy,
    input  logic i_vblank,
    output logic o_nfi_gnt,
    output logic o_fcl_gnt,
    output logic o_front_sel,
    output logic o_swap,
    output logic o_err
);

    localparam int CW = $clog2(START_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(START_TIMEOUT - 1);

    fba_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          nfi_gnt_q, nfi_gnt_d;
    logic          fcl_gnt_q, fcl_gnt_d;
    bank_sel_t     front_q, front_d;
    logic          swap_q, swap_d;
    logic          err_q, err_d;
    logic          rdy_q;
    logic          nfi_busy_q, fcl_busy_q;
    logic          nfi_owned, fcl_owned;
    logic          nfi_unsol, fcl_unsol;
    logic          swap_ok;

`ifdef FBA_VBLANK_SYNC_EN
    assign swap_ok = i_vblank;
`else
    logic unused_vblank;
    assign unused_vblank = i_vblank;
    assign swap_ok       = 1'b1;
`endif

    // A busy edge from an engine that does not own the bank is a protocol error.
    assign nfi_owned = (state_q == GNT_NFI) || (state_q == RUN_NFI);
    assign fcl_owned = (state_q == GNT_FCL) || (state_q == RUN_FCL);
    assign nfi_unsol = i_nfi_busy && !nfi_busy_q && !nfi_owned;
    assign fcl_unsol = i_fcl_busy && !fcl_busy_q && !fcl_owned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            nfi_gnt_q  <= 1'b0;
            fcl_gnt_q  <= 1'b0;
            front_q    <= BANK_A;
            swap_q     <= 1'b0;
            err_q      <= 1'b0;
            rdy_q      <= 1'b0;
            nfi_busy_q <= 1'b0;
            fcl_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nfi_gnt_q  <= nfi_gnt_d;
            fcl_gnt_q  <= fcl_gnt_d;
            front_q    <= front_d;
            swap_q     <= swap_d;
            err_q      <= err_d;
            rdy_q      <= 1'b1;
            nfi_busy_q <= i_nfi_busy;
            fcl_busy_q <= i_fcl_busy;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        nfi_gnt_d = nfi_gnt_q;
        fcl_gnt_d = fcl_gnt_q;
        front_d   = front_q;
        swap_d    = 1'b0;
        err_d     = nfi_unsol || fcl_unsol;
        case (state_q)
            IDLE: begin
                nfi_gnt_d = 1'b0;
                fcl_gnt_d = 1'b0;
                // rdy_q holds off grants for the first cycle out of reset
                if (rdy_q) begin
                    if (i_fcl_req && (!i_nfi_req || (FCL_PRIO != 0))) begin
                        state_d   = GNT_FCL;
                        fcl_gnt_d = 1'b1;
                    end else if (i_nfi_req) begin
                        state_d   = GNT_NFI;
                        nfi_gnt_d = 1'b1;
                    end
                end
            end
            GNT_NFI: begin
                if (i_nfi_busy) begin
                    state_d = RUN_NFI;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = IDLE;
                    nfi_gnt_d = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GNT_FCL: begin
                if (i_fcl_busy) begin
                    state_d = RUN_FCL;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = IDLE;
                    fcl_gnt_d = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN_NFI: begin
                if (!i_nfi_busy) begin
                    state_d   = SWAP_WAIT;
                    nfi_gnt_d = 1'b0;
                end
            end
            RUN_FCL: begin
                if (!i_fcl_busy) begin
                    state_d   = SWAP_WAIT;
                    fcl_gnt_d = 1'b0;
                end
            end
            SWAP_WAIT: begin
                if (swap_ok) begin
                    state_d = IDLE;
                    front_d = (front_q == BANK_A) ? BANK_B : BANK_A;
                    swap_d  = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                nfi_gnt_d = 1'b0;
                fcl_gnt_d = 1'b0;
            end
        endcase
    end

    assign o_nfi_gnt   = nfi_gnt_q;
    assign o_fcl_gnt   = fcl_gnt_q;
    assign o_front_sel = front_q;
    assign o_swap      = swap_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_field_bank_arbiter.sv
// tb/tb_field_bank_arbiter.sv - directed bench for field_bank_arbiter, instance 0 loader-priority, instance 1 iterator-priority
module tb_field_bank_arbiter;

    logic clk;
    logic rst;
    logic nfi_req  [2];
    logic fcl_req  [2];
    logic nfi_busy [2];
    logic fcl_busy [2];
    logic vblank   [2];
    logic nfi_gnt  [2];
    logic fcl_gnt  [2];
    logic front    [2];
    logic swap     [2];
    logic err      [2];
    logic front_exp[2];

    int checks;
    int errors;

    field_bank_arbiter #(.FCL_PRIO(1), .START_TIMEOUT(16)) u_dut0 (
        .clk(clk), .rst(rst),
        .i_nfi_req(nfi_req[0]), .i_fcl_req(fcl_req[0]),
        .i_nfi_busy(nfi_busy[0]), .i_fcl_busy(fcl_busy[0]),
        .i_vblank(vblank[0]),
        .o_nfi_gnt(nfi_gnt[0]), .o_fcl_gnt(fcl_gnt[0]),
        .o_front_sel(front[0]), .o_swap(swap[0]), .o_err(err[0])
    );

    field_bank_arbiter #(.FCL_PRIO(0), .START_TIMEOUT(16)) u_dut1 (
        .clk(clk), .rst(rst),
        .i_nfi_req(nfi_req[1]), .i_fcl_req(fcl_req[1]),
        .i_nfi_busy(nfi_busy[1]), .i_fcl_busy(fcl_busy[1]),
        .i_vblank(vblank[1]),
        .o_nfi_gnt(nfi_gnt[1]), .o_fcl_gnt(fcl_gnt[1]),
        .o_front_sel(front[1]), .o_swap(swap[1]), .o_err(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs a granted job to completion: busy for one cycle, then drop, then expect the swap.
    task automatic run_job(input int d, input bit f);
        if (f) begin
            fcl_req[d]  = 1'b0;
            fcl_busy[d] = 1'b1;
        end else begin
            nfi_req[d]  = 1'b0;
            nfi_busy[d] = 1'b1;
        end
        tick();
        check("run_gnt", f ? {nfi_gnt[d], fcl_gnt[d]} : {fcl_gnt[d], nfi_gnt[d]}, 8'h1);
        fcl_busy[d] = 1'b0;
        nfi_busy[d] = 1'b0;
        tick();
        check("swapwait_gnt", {nfi_gnt[d], fcl_gnt[d]}, 8'h0);
        check("swapwait_noswap", swap[d], 8'h0);
        front_exp[d] = ~front_exp[d];
        tick();
        check("swap_pulse", swap[d], 8'h1);
        check("swap_front", front[d], front_exp[d]);
        tick();
        check("swap_end", swap[d], 8'h0);
        check("job_err_quiet", err[d], 8'h0);
    endtask

    initial begin
        int swaps;
        int gnt_hi;
        int errs;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        for (int d = 0; d < 2; d++) begin
            nfi_req[d]   = 1'b0;
            fcl_req[d]   = 1'b0;
            nfi_busy[d]  = 1'b0;
            fcl_busy[d]  = 1'b0;
            vblank[d]    = 1'b1;
            front_exp[d] = 1'b0;
        end
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            check("rst_gnt", {nfi_gnt[d], fcl_gnt[d]}, 8'h0);
            check("rst_front", front[d], 8'h0);
            check("rst_swap_err", {swap[d], err[d]}, 8'h0);
        end

        // Single iterator job; grant only on the second edge after reset release
        rst        = 1'b0;
        nfi_req[0] = 1'b1;
        tick();
        check("first_edge_no_gnt", nfi_gnt[0], 8'h0);
        tick();
        check("nfi_gnt", {nfi_gnt[0], fcl_gnt[0]}, 8'h2);
        nfi_req[0] = 1'b0;
        tick();
        tick();
        nfi_busy[0] = 1'b1;
        gnt_hi = 0;
        swaps  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (nfi_gnt[0]) gnt_hi++;
            if (swap[0]) swaps++;
        end
        check("nfi_gnt_held", gnt_hi[7:0], 8'd20);
        nfi_busy[0] = 1'b0;
        tick();
        check("nfi_gnt_drop", nfi_gnt[0], 8'h0);
        check("front_before_swap", front[0], 8'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (swap[0]) swaps++;
        end
        check("single_swap", swaps[7:0], 8'd1);
        check("front_after_swap", front[0], 8'h1);
        front_exp[0] = 1'b1;

        // Simultaneous requests, loader priority; iterator stays pending
        nfi_req[0] = 1'b1;
        fcl_req[0] = 1'b1;
        tick();
        check("prio1_fcl_only", {nfi_gnt[0], fcl_gnt[0]}, 8'h1);
        run_job(0, 1'b1);
        check("prio1_nfi_follows", {nfi_gnt[0], fcl_gnt[0]}, 8'h2);
        run_job(0, 1'b0);

        // Simultaneous requests, iterator priority on the second instance
        nfi_req[1] = 1'b1;
        fcl_req[1] = 1'b1;
        tick();
        check("prio0_nfi_only", {nfi_gnt[1], fcl_gnt[1]}, 8'h2);
        run_job(1, 1'b0);
        check("prio0_fcl_follows", {nfi_gnt[1], fcl_gnt[1]}, 8'h1);
        run_job(1, 1'b1);

        // Start timeout: loader granted, never goes busy
        fcl_req[0] = 1'b1;
        tick();
        fcl_req[0] = 1'b0;
        gnt_hi = 0;
        errs   = 0;
        for (int i = 0; i < 15; i++) begin
            if (fcl_gnt[0]) gnt_hi++;
            if (err[0]) errs++;
            tick();
        end
        if (fcl_gnt[0]) gnt_hi++;
        check("timeout_gnt_cycles", gnt_hi[7:0], 8'd16);
        tick();
        check("timeout_gnt_low", fcl_gnt[0], 8'h0);
        check("timeout_err", err[0], 8'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (err[0]) errs++;
            if (swap[0]) errs++;
        end
        check("timeout_one_err_no_swap", errs[7:0], 8'd0);
        check("timeout_front", front[0], front_exp[0]);

        // Unsolicited busy in IDLE: one error pulse per rising edge
        nfi_busy[0] = 1'b1;
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (err[0]) errs++;
        end
        check("unsol_single_err", errs[7:0], 8'd1);
        nfi_busy[0] = 1'b0;
        tick();
        tick();

`ifdef FBA_VBLANK_SYNC_EN
        // Swap waits for vblank rising 100 cycles after the job ends
        nfi_req[0] = 1'b1;
        tick();
        nfi_req[0]  = 1'b0;
        nfi_busy[0] = 1'b1;
        tick();
        nfi_busy[0] = 1'b0;
        vblank[0]   = 1'b0;
        swaps = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (swap[0]) swaps++;
        end
        check("vblank_hold", swaps[7:0], 8'd0);
        check("vblank_front_hold", front[0], front_exp[0]);
        vblank[0] = 1'b1;
        tick();
        front_exp[0] = ~front_exp[0];
        check("vblank_swap", swap[0], 8'h1);
        check("vblank_front", front[0], front_exp[0]);
        tick();
        check("vblank_swap_end", swap[0], 8'h0);
`endif

        if (front_exp[0] == 1'b0) begin
            nfi_req[0] = 1'b1;
            tick();
            run_job(0, 1'b0);
        end

        // Async reset in the middle of an iterator run with front bank B
        nfi_req[0] = 1'b1;
        tick();
        nfi_req[0]  = 1'b0;
        nfi_busy[0] = 1'b1;
        tick();
        check("midrun_gnt", {nfi_gnt[0], front[0]}, 8'h3);
        rst         = 1'b1;
        nfi_busy[0] = 1'b0;
        #1;
        check("async_rst_gnt", {nfi_gnt[0], fcl_gnt[0]}, 8'h0);
        check("async_rst_front", front[0], 8'h0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("post_rst_quiet", {swap[0], err[0], nfi_gnt[0]}, 8'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/field_bank_arbiter.md
FIELD_BANK_ARBITER -- requirements
Module: field_bank_arbiter

Interface
REQ-001 Parameter: FCL_PRIO, default 1, 1 = loader wins simultaneous requests, 0 = next-field iterator wins.
REQ-002 Parameter: START_TIMEOUT, default 16, max cycles a granted engine may take to assert busy; legal range 2..255.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 i_nfi_req  input  1  iterator requests one generation (level, held until granted).
REQ-006 i_fcl_req  input  1  loader requests one config load (level, held until granted).
REQ-007 i_nfi_busy  input  1  iterator running (is_simulating).
REQ-008 i_fcl_busy  input  1  loader running (is_loading).
REQ-009 i_vblank  input  1  display vertical blanking, level, synchronous to clk.
REQ-010 o_nfi_gnt  output  1  iterator owns back bank write and front bank neighbour-read ports.
REQ-011 o_fcl_gnt  output  1  loader owns back bank write port.
REQ-012 o_front_sel  output  1  bank shown and read as source: 0 = A, 1 = B; back bank = ~o_front_sel.
REQ-013 o_swap  output  1  one-cycle pulse in the cycle o_front_sel toggles.
REQ-014 o_err  output  1  one-cycle pulse on start timeout or unsolicited busy.

Function
REQ-015 FSM states SHALL be IDLE, GNT_NFI, GNT_FCL, RUN_NFI, RUN_FCL, SWAP_WAIT; all outputs registered.
REQ-016 IDLE: on req, next cycle enters GNT_x with o_x_gnt=1; both req same cycle -> FCL_PRIO decides, loser stays pending.
REQ-017 At most one grant SHALL be high in any cycle.
REQ-018 GNT_x: busy_x high -> RUN_x next cycle, grant held; timeout counter counts cycles in GNT_x.
REQ-019 GNT_x: counter reaches START_TIMEOUT without busy -> IDLE, grant low, o_err pulse, no swap.
REQ-020 RUN_x: busy_x falling (high to low) -> SWAP_WAIT, grant low next cycle.
REQ-021 SWAP_WAIT: toggle o_front_sel, pulse o_swap, return to IDLE (timing per REQ-028/029).
REQ-022 Requests arriving outside IDLE SHALL be ignored (not latched); requesters hold level.
REQ-023 busy of the non-granted engine high in any state, or any busy high in IDLE, SHALL pulse o_err once per rising edge of that busy; FSM unaffected.
REQ-024 Back-to-back: IDLE with req pending immediately after swap -> GNT in the following cycle (one IDLE cycle minimum between jobs).

Reset
REQ-025 rst high (any time, including mid-RUN) -> IDLE, o_nfi_gnt=0, o_fcl_gnt=0, o_front_sel=0, o_swap=0, o_err=0, counter=0, within the same cycle (asynchronous).
REQ-026 After rst deasserts, first grant possible on the second rising edge.

Configuration
REQ-027 Macro FBA_VBLANK_SYNC_EN selects swap timing.
REQ-028 Defined: SWAP_WAIT holds until i_vblank=1; toggle/pulse in first cycle with i_vblank=1 (same cycle if already high on entry).
REQ-029 Undefined: SWAP_WAIT lasts exactly one cycle, i_vblank ignored (port kept, unused).

Structure
REQ-030 Package defs SHALL hold fba_state_t enum and bank_sel_t (BANK_A=0, BANK_B=1).
REQ-031 No sub-module; timeout counter $clog2(START_TIMEOUT+1) bits inline.
REQ-032 Bank port muxing stays in top, driven by o_front_sel and grants.

Verification
REQ-033 Reset, nfi_req=1, busy rises 3 cycles after gnt, held 20 cycles, vblank tied 1 -> gnt 1 cycle after req, front_sel 0->1, one o_swap.
REQ-034 nfi_req and fcl_req same cycle, FCL_PRIO=1 -> o_fcl_gnt only; after fcl job and swap, o_nfi_gnt follows; repeat with FCL_PRIO=0, reversed order.
REQ-035 fcl_req, busy never asserted, START_TIMEOUT=16 -> gnt drops after 16 cycles, o_err one pulse, front_sel unchanged.
REQ-036 FBA_VBLANK_SYNC_EN defined, job ends, vblank rises 100 cycles later -> swap exactly on vblank cycle; undefined -> swap 1 cycle after busy falls.
REQ-037 rst pulsed mid-RUN_NFI with front_sel=1 -> gnt 0 and front_sel 0 immediately; i_nfi_busy high in IDLE -> single o_err.
